uart_tx_slv: RTL
================

UART_TX_SLV -- requirements
Module: uart_tx_slv

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0300, interconnect base; decode on addr[31:4].
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, TX FIFO entries; a power of two, 2..64.
REQ-003 SHALL have parameter CLK_DIV, default 16'd868, reset value of the baud divisor.
REQ-004 SHALL have one clock and a synchronous, active-high reset, as listed below.
REQ-005 SHALL have port clk  input  1  system clock, all logic on the rising edge.
REQ-006 SHALL have port c_sys_rst  input  1  synchronous active-high reset.
REQ-007 SHALL have ports ic0_c_axi_mst_wr_valid and ic0_c_axi_mst_rd_valid  input  1  master write and read strobes, each 1 cycle.
REQ-008 SHALL have ports ic0_axi_mst_wr_addr, ic0_axi_mst_wr_data and ic0_axi_mst_rd_addr  input  32  write address, write data and read address.
REQ-009 SHALL have port ic0_axi_mst_wr_strobe  input  4  byte-lane enables.
REQ-010 SHALL have port ic0_c_axi_slv_rd_ready_3  output  1  read-data-valid pulse.
REQ-011 SHALL have port ic0_axi_slv_rd_data_3  output  32  read data.
REQ-012 SHALL have port uart_txd  output  1  serial line, idle high.

Function
REQ-013 SHALL implement this register map: 0x0 TXDATA (write only, reads 0); 0x4 STATUS {28'b0, ovf, busy, empty, full}, ovf is write-1-to-clear; 0x8 DIV [15:0]; 0xC and any unmapped offset read 0 and ignore writes.
REQ-014 SHALL register reads: rd_valid with a decoded address gives rd_ready=1 and the data on the following cycle, for exactly 1 cycle. Undecoded addresses give no response and rd_data holds 0.
REQ-015 SHALL push wr_data[7:0] into the FIFO on a TXDATA write with strobe[0]=1. With strobe[0]=0 the write is ignored.
REQ-016 SHALL drop a push when the FIFO is full, unless a pop occurs in the same cycle, and SHALL set ovf on every dropped push.
REQ-017 SHALL, on a simultaneous push and pop, keep count unchanged, and the push SHALL succeed even when full.
REQ-018 SHALL update DIV on a DIV write per byte strobes [0] and [1]. The bit period is max(DIV,1) clock cycles, and a new DIV takes effect at the next bit boundary.
REQ-019 SHALL run the transmit FSM IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE. It leaves IDLE on the cycle after the FIFO is non-empty; the pop happens on the IDLE->START transition.
REQ-020 SHALL hold each serial bit for exactly one bit period, driving uart_txd 0 in START, the data bit in DATA, and 1 in STOP and IDLE.
REQ-021 SHALL go STOP -> START directly (back-to-back frames, no idle gap) when the FIFO is non-empty at the end of STOP.
REQ-022 SHALL drive status busy = (state != IDLE); empty and full reflect count==0 and count==FIFO_DEPTH.
REQ-023 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH, with count of width clog2(FIFO_DEPTH)+1.

Reset
REQ-024 SHALL, on c_sys_rst, set state=IDLE, uart_txd=1, FIFO empty (pointers and count 0), ovf=0, DIV=CLK_DIV, rd_ready=0, rd_data=0, and reset the bit and baud counters to 0.
REQ-025 SHALL abort any frame in flight when reset is asserted mid-frame: uart_txd is 1 from the cycle after the reset edge and queued bytes are discarded.
REQ-026 SHALL ignore bus accesses in any cycle with c_sys_rst=1.

Configuration
REQ-027 SHALL, with UART_TX_PARITY_EN defined, add state PARITY between DATA and STOP that sends the even-parity bit (XOR of the 8 data bits) for one bit period; STATUS bit4 reads 1.
REQ-028 SHALL, without UART_TX_PARITY_EN, send 8N1 frames, have no PARITY state, and STATUS bit4 reads 0.

Structure
REQ-029 SHALL define in package soc_uart_pkg the state enum, the register offset constants (TXDATA/STATUS/DIV) and the STATUS bit positions.
REQ-030 SHALL place the FIFO storage in sub-module uart_tx_fifo (push, pop, full, empty, count); the bus decode and FSM stay in uart_tx_slv.

Verification
REQ-031 SHALL cover: DIV=4, write 0xA5 to TXDATA -> uart_txd shows 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, busy 1 for 40 cycles.
REQ-032 SHALL cover: DIV=2, write 9 bytes back-to-back at depth 8 while the FSM is IDLE -> the first byte pops, the 9th is accepted, a 10th sets ovf=1; STATUS read returns full=1.
REQ-033 SHALL cover: read 0x4 at cycle N -> rd_ready_3=1 and data valid at N+1 only; read 0xC -> data 0; read BASE+0x10 -> no rd_ready.
REQ-034 SHALL cover: write STATUS with bit3=1 while ovf=1 -> ovf=0 next cycle; TXDATA with strobe=4'b0010 -> no push.
REQ-035 SHALL cover: assert c_sys_rst during DATA bit 3 -> uart_txd=1, empty=1, DIV=868 the next cycle.
REQ-036 SHALL cover: with UART_TX_PARITY_EN defined, send 0x07 -> parity bit 1 before the stop bit, 11 bit periods total.

Source files
------------

// File: rtl/uart_tx_slv_pkg.sv
// soc_uart_pkg: shared state encoding, register offsets and STATUS bit positions for uart_tx_slv.
// UART_TX_PARITY_EN adds the PARITY state and sets the STATUS parity-enable bit.
package soc_uart_pkg;
`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_PARITY} state_e;
   localparam bit PAR_EN = 1'b1;
`else
   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;
   localparam bit PAR_EN = 1'b0;
`endif
   localparam logic [3:0] OFS_TXDATA = 4'h0, OFS_STATUS = 4'h4, OFS_DIV = 4'h8;
   localparam int STAT_FULL = 0, STAT_EMPTY = 1, STAT_BUSY = 2, STAT_OVF = 3, STAT_PAR = 4;
   function automatic logic [15:0] bit_period(input logic [15:0] div);
      return div == 16'd0 ? 16'd1 : div;
   endfunction
endpackage

// File: rtl/uart_tx_slv_if.sv
// uart_tx_slv_if: interconnect port-0 write/read strobes and read response for the UART TX slave.
interface uart_tx_slv_if;
   logic        ic0_c_axi_mst_wr_valid;
   logic        ic0_c_axi_mst_rd_valid;
   logic [31:0] ic0_axi_mst_wr_addr;
   logic [31:0] ic0_axi_mst_wr_data;
   logic [31:0] ic0_axi_mst_rd_addr;
   logic [3:0]  ic0_axi_mst_wr_strobe;
   logic        ic0_c_axi_slv_rd_ready_3;
   logic [31:0] ic0_axi_slv_rd_data_3;
   modport master (
      output ic0_c_axi_mst_wr_valid, ic0_c_axi_mst_rd_valid, ic0_axi_mst_wr_addr,
             ic0_axi_mst_wr_data, ic0_axi_mst_rd_addr, ic0_axi_mst_wr_strobe,
      input  ic0_c_axi_slv_rd_ready_3, ic0_axi_slv_rd_data_3
   );
   modport slave (
      input  ic0_c_axi_mst_wr_valid, ic0_c_axi_mst_rd_valid, ic0_axi_mst_wr_addr,
             ic0_axi_mst_wr_data, ic0_axi_mst_rd_addr, ic0_axi_mst_wr_strobe,
      output ic0_c_axi_slv_rd_ready_3, ic0_axi_slv_rd_data_3
   );
endinterface

// File: rtl/uart_tx_slv_fifo.sv
// uart_tx_fifo: byte FIFO with power-of-two depth; a push while full succeeds only alongside a pop.
module uart_tx_fifo #(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);
   localparam int AW = $clog2(DEPTH);
   logic [7:0] mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [AW:0] count;
   logic push_ok, pop_ok;
   assign full = count == (AW + 1)'(DEPTH);
   assign empty = count == '0;
   assign push_ok = push && (!full || pop);
   assign pop_ok = pop && !empty;
   assign dout = mem[rptr];
   always_ff @(posedge clk) if (push_ok) mem[wptr] <= din;
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         count <= '0;
      end else begin
         if (push_ok) wptr <= wptr + 1'b1;
         if (pop_ok) rptr <= rptr + 1'b1;
         count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
      end
   end
endmodule

// File: rtl/uart_tx_slv.sv
// uart_tx_slv: memory-mapped UART transmitter with TX FIFO, STATUS and baud divisor registers.
// Define UART_TX_PARITY_EN for 8E1 framing (even-parity bit between DATA and STOP).
module uart_tx_slv
   import soc_uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0300,
   parameter int FIFO_DEPTH = 8,
   parameter logic [15:0] CLK_DIV = 16'd868
) (
   input  logic         clk,
   input  logic         c_sys_rst,
   uart_tx_slv_if.slave bus,
   output logic         uart_txd
);
   localparam logic [2:0] IDLE = ST_IDLE, START = ST_START, DATA = ST_DATA, STOP = ST_STOP;
   logic wr_hit, rd_hit, push, pop, full, empty, tick, ovf, shifting;
   logic [2:0] state, bit_cnt, after_data;
   logic [3:0] wofs, rofs;
   logic [7:0] dout;
   logic [8:0] sh;
   logic [15:0] div, per, baud;
   logic [31:0] status;
   assign wofs = bus.ic0_axi_mst_wr_addr[3:0];
   assign rofs = bus.ic0_axi_mst_rd_addr[3:0];
   assign wr_hit = bus.ic0_c_axi_mst_wr_valid && bus.ic0_axi_mst_wr_addr[31:4] == BASE_ADDR[31:4];
   assign rd_hit = bus.ic0_c_axi_mst_rd_valid && bus.ic0_axi_mst_rd_addr[31:4] == BASE_ADDR[31:4];
   assign push = wr_hit && wofs == OFS_TXDATA && bus.ic0_axi_mst_wr_strobe[0];
   assign tick = baud == per - 16'd1;
   assign pop = !empty && (state == IDLE || (state == STOP && tick));
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] PARITY = ST_PARITY;
   assign after_data = PARITY;
   assign shifting = state == DATA || state == PARITY;
`else
   assign after_data = STOP;
   assign shifting = state == DATA;
`endif
   assign uart_txd = state == START ? 1'b0 : shifting ? sh[0] : 1'b1;
   uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .rst(c_sys_rst), .push(push), .pop(pop),
      .din(bus.ic0_axi_mst_wr_data[7:0]), .dout(dout), .full(full), .empty(empty)
   );
   always_comb begin
      status = '0;
      status[STAT_FULL] = full;
      status[STAT_EMPTY] = empty;
      status[STAT_BUSY] = state != IDLE;
      status[STAT_OVF] = ovf;
      status[STAT_PAR] = PAR_EN;
   end
   always_ff @(posedge clk) begin
      if (c_sys_rst) begin
         div <= CLK_DIV;
         ovf <= 1'b0;
         bus.ic0_c_axi_slv_rd_ready_3 <= 1'b0;
         bus.ic0_axi_slv_rd_data_3 <= '0;
      end else begin
         if (wr_hit && wofs == OFS_DIV && bus.ic0_axi_mst_wr_strobe[0]) div[7:0] <= bus.ic0_axi_mst_wr_data[7:0];
         if (wr_hit && wofs == OFS_DIV && bus.ic0_axi_mst_wr_strobe[1]) div[15:8] <= bus.ic0_axi_mst_wr_data[15:8];
         if (push && full && !pop) ovf <= 1'b1;
         else if (wr_hit && wofs == OFS_STATUS && bus.ic0_axi_mst_wr_strobe[0] && bus.ic0_axi_mst_wr_data[STAT_OVF]) ovf <= 1'b0;
         bus.ic0_c_axi_slv_rd_ready_3 <= rd_hit;
         bus.ic0_axi_slv_rd_data_3 <= !rd_hit ? '0 : rofs == OFS_STATUS ? status : rofs == OFS_DIV ? {16'h0, div} : '0;
      end
   end
   // sh holds {parity, data}; after eight shifts the parity bit sits in sh[0]
   always_ff @(posedge clk) begin
      if (c_sys_rst) begin
         state <= IDLE;
         bit_cnt <= '0;
         baud <= '0;
         per <= bit_period(CLK_DIV);
         sh <= '1;
      end else if (state == IDLE || tick) begin
         baud <= '0;
         per <= bit_period(div);
         if (state == DATA) begin
            sh <= {1'b1, sh[8:1]};
            bit_cnt <= bit_cnt + 3'd1;
            state <= bit_cnt == 3'd7 ? after_data : DATA;
         end else if (state == START) state <= DATA;
         else if (state == IDLE || state == STOP) begin
            state <= empty ? IDLE : START;
            sh <= {^dout, dout};
            bit_cnt <= '0;
         end else state <= STOP;
      end else baud <= baud + 16'd1;
   end
endmodule
